fir_tap_loader: RTL and testbench

// - Source side of the configurable_fir tap-programming port. Buffers G_NUM_TAPS coefficients written by a

---
 rtl/fir_tap_loader.sv | 187 ++++++++++++++++++
 tb/tb_fir_tap_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_loader.sv
// fir_tap_loader: buffers host-written FIR taps and streams them to the FIR tap port.
// Optional FIR_TAP_LOADER_CHECKSUM_EN adds tap_checksum, a signed running sum of sent taps.
module fir_tap_loader #(
    parameter int G_NUM_TAPS     = 16,
    parameter int G_TAP_WIDTH    = 16,
    parameter int G_RESET_CYCLES = 4,
    parameter int G_DONE_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [$clog2(G_NUM_TAPS)-1:0] cfg_wr_addr,
    input  logic [G_TAP_WIDTH-1:0]        cfg_wr_data,
    input  logic                          cfg_wr_valid,
    output logic                          cfg_wr_ready,
    input  logic                          start,
    output logic                          busy,
    output logic                          load_done,
    output logic                          load_error,
    output logic                          fir_enable,
    output logic [G_TAP_WIDTH-1:0]        tap_dout,
    output logic                          tap_dout_valid,
    input  logic                          tap_dout_ready,
    input  logic                          tap_done_in
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
    ,
    output logic signed [G_TAP_WIDTH+$clog2(G_NUM_TAPS)-1:0] tap_checksum
`endif
);

    localparam int AW = $clog2(G_NUM_TAPS);
    localparam int RW = $clog2(G_RESET_CYCLES + 1);
    localparam int TW = $clog2(G_DONE_TIMEOUT + 1);
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
    localparam int CW = G_TAP_WIDTH + AW;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIR_RESET,
        S_STREAM,
        S_WAIT_DONE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [G_TAP_WIDTH-1:0] ram [G_NUM_TAPS];

    logic [AW-1:0] tap_cnt;
    logic [AW-1:0] tap_nxt;
    logic [RW-1:0] rst_cnt;
    logic [TW-1:0] to_cnt;
    logic          wr_en;
    logic          tap_xfer;
    logic          tap_last;
    logic          to_last;

    assign tap_nxt  = tap_cnt + AW'(1);
    assign tap_last = (tap_cnt == AW'(G_NUM_TAPS - 1));
    assign to_last  = (to_cnt == TW'(G_DONE_TIMEOUT - 1));
    assign tap_xfer = tap_dout_valid & tap_dout_ready;
    assign wr_en    = cfg_wr_valid & cfg_wr_ready;

    // Host tap storage; writes only land while the loader is not busy
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived control outputs
    always_comb begin
        state_nxt    = state;
        fir_enable   = 1'b0;
        busy         = 1'b0;
        cfg_wr_ready = 1'b0;
        unique case (state)
            S_IDLE: begin
                cfg_wr_ready = 1'b1;
                if (start) state_nxt = S_FIR_RESET;
            end
            S_FIR_RESET: begin
                busy = 1'b1;
                if (rst_cnt == '0) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                busy       = 1'b1;
                fir_enable = 1'b1;
                if (tap_xfer && tap_last) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                busy       = 1'b1;
                fir_enable = 1'b1;
                if (tap_done_in) begin
                    state_nxt = S_DONE;
                end else if (to_last) begin
                    state_nxt = S_ERROR;
                end
            end
            S_DONE: begin
                fir_enable   = 1'b1;
                cfg_wr_ready = 1'b1;
                if (start) state_nxt = S_FIR_RESET;
            end
            S_ERROR: begin
                cfg_wr_ready = 1'b1;
                if (start) state_nxt = S_FIR_RESET;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters, tap output register and sticky status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap_cnt        <= '0;
            rst_cnt        <= '0;
            to_cnt         <= '0;
            tap_dout       <= '0;
            tap_dout_valid <= 1'b0;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
            tap_checksum   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        rst_cnt    <= RW'(G_RESET_CYCLES - 1);
                        tap_cnt    <= '0;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
                        tap_checksum <= '0;
`endif
                    end
                end
                S_FIR_RESET: begin
                    if (rst_cnt == '0) begin
                        tap_dout       <= ram[tap_cnt];
                        tap_dout_valid <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - RW'(1);
                    end
                end
                S_STREAM: begin
                    if (tap_xfer) begin
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
                        tap_checksum <= tap_checksum +
                            {{(CW - G_TAP_WIDTH){tap_dout[G_TAP_WIDTH-1]}}, tap_dout};
`endif
                        if (tap_last) begin
                            tap_dout_valid <= 1'b0;
                            to_cnt         <= '0;
                        end else begin
                            tap_cnt  <= tap_nxt;
                            tap_dout <= ram[tap_nxt];
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (tap_done_in) begin
                        load_done <= 1'b1;
                    end else if (to_last) begin
                        load_error <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_loader.sv
// tb_fir_tap_loader: directed bench for fir_tap_loader with a tap scoreboard.
// Define FIR_TAP_LOADER_CHECKSUM_EN to also check the checksum output.
module tb_fir_tap_loader;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int R  = 4;
    localparam int T  = 64;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] cfg_wr_addr;
    logic [W-1:0]  cfg_wr_data;
    logic          cfg_wr_valid;
    logic          cfg_wr_ready;
    logic          start;
    logic          busy;
    logic          load_done;
    logic          load_error;
    logic          fir_enable;
    logic [W-1:0]  tap_dout;
    logic          tap_dout_valid;
    logic          tap_dout_ready;
    logic          tap_done_in;
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
    logic signed [W+AW-1:0] tap_checksum;
`endif

    always #5 clk = ~clk;

    fir_tap_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_wr_addr    (cfg_wr_addr),
        .cfg_wr_data    (cfg_wr_data),
        .cfg_wr_valid   (cfg_wr_valid),
        .cfg_wr_ready   (cfg_wr_ready),
        .start          (start),
        .busy           (busy),
        .load_done      (load_done),
        .load_error     (load_error),
        .fir_enable     (fir_enable),
        .tap_dout       (tap_dout),
        .tap_dout_valid (tap_dout_valid),
        .tap_dout_ready (tap_dout_ready),
        .tap_done_in    (tap_done_in)
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
        ,
        .tap_checksum   (tap_checksum)
`endif
    );

    int           checks = 0;
    int           errors = 0;
    int           popped = 0;
    logic [W-1:0] model [N];
    logic [W-1:0] exp_q [$];
    logic         hold_prev = 1'b0;
    logic [W-1:0] prev_dout = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop expected tap on every handshake, check hold while stalled
    always @(negedge clk) begin
        if (reset_n) begin
            if (hold_prev) begin
                chk("hold_valid", 32'(tap_dout_valid), 32'd1);
                chk("hold_data", 32'(tap_dout), 32'(prev_dout));
            end
            if (tap_dout_valid && tap_dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_tap", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("tap_data", 32'(tap_dout), 32'(exp_q.pop_front()));
                end
                popped++;
            end
            hold_prev = tap_dout_valid && !tap_dout_ready;
            prev_dout = tap_dout;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic write_tap(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        cfg_wr_addr  = a;
        cfg_wr_data  = d;
        cfg_wr_valid = 1'b1;
        model[a]     = d;
        @(posedge clk);
        #1 cfg_wr_valid = 1'b0;
    endtask

    task automatic start_load(input logic wr, input logic [AW-1:0] a,
                              input logic [W-1:0] d);
        @(negedge clk);
        start = 1'b1;
        if (wr) begin
            cfg_wr_addr  = a;
            cfg_wr_data  = d;
            cfg_wr_valid = 1'b1;
            model[a]     = d;
        end
        popped = 0;
        for (int k = 0; k < N; k++) exp_q.push_back(model[k]);
        @(posedge clk);
        #1;
        start        = 1'b0;
        cfg_wr_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!tap_dout_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic stream(input logic toggle, output int c);
        c = 0;
        while (tap_dout_valid && c < 200) begin
            @(posedge clk);
            #1 c++;
            if (toggle) tap_dout_ready = ~tap_dout_ready;
            if (toggle && c == 5) tap_done_in = 1'b1;
            if (toggle && c == 6) tap_done_in = 1'b0;
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        tap_done_in = 1'b1;
        @(posedge clk);
        #1 tap_done_in = 1'b0;
        chk("load_done_set", 32'(load_done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_fir_en", 32'(fir_enable), 32'd1);
        chk("done_wr_ready", 32'(cfg_wr_ready), 32'd1);
    endtask

    initial begin
        int n;
        int c;
        int e;
        reset_n        = 1'b0;
        cfg_wr_addr    = '0;
        cfg_wr_data    = '0;
        cfg_wr_valid   = 1'b0;
        start          = 1'b0;
        tap_dout_ready = 1'b0;
        tap_done_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fir_en", 32'(fir_enable), 32'd0);
        chk("rst_valid", 32'(tap_dout_valid), 32'd0);
        chk("rst_dout", 32'(tap_dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_error", 32'(load_error), 32'd0);
        chk("rst_wr_ready", 32'(cfg_wr_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < N; k++) write_tap(AW'(k), W'(k * 256));

        // back-to-back load with ready held high
        tap_dout_ready = 1'b1;
        start_load(1'b0, '0, '0);
        chk("fr_busy", 32'(busy), 32'd1);
        chk("fr_fir_en", 32'(fir_enable), 32'd0);
        chk("fr_wr_ready", 32'(cfg_wr_ready), 32'd0);
        wait_valid(n);
        chk("latency", 32'(n + 1), 32'(R + 1));
        chk("st_fir_en", 32'(fir_enable), 32'd1);
        stream(1'b0, c);
        chk("b2b_cycles", 32'(c), 32'(N));
        chk("b2b_count", 32'(popped), 32'(N));
        chk("b2b_q_empty", 32'(exp_q.size()), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_no_done", 32'(load_done), 32'd0);
        pulse_done();

        // ready toggling, early tap_done_in must be ignored
        tap_dout_ready = 1'b0;
        start_load(1'b0, '0, '0);
        chk("restart_clr_done", 32'(load_done), 32'd0);
        wait_valid(n);
        stream(1'b1, c);
        chk("tog_count", 32'(popped), 32'(N));
        chk("tog_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("early_done_ign", 32'(load_done), 32'd0);
        pulse_done();

        // timeout in WAIT_DONE
        tap_dout_ready = 1'b1;
        start_load(1'b0, '0, '0);
        wait_valid(n);
        stream(1'b0, c);
        e = 0;
        while (!load_error && e < 200) begin
            @(posedge clk);
            #1 e++;
        end
        chk("timeout_cycles", 32'(e), 32'(T));
        chk("err_flag", 32'(load_error), 32'd1);
        chk("err_fir_en", 32'(fir_enable), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_wr_ready", 32'(cfg_wr_ready), 32'd1);

        // same-cycle write with start, then blocked write mid-stream
        tap_dout_ready = 1'b0;
        start_load(1'b1, AW'(0), 16'h1234);
        wait_valid(n);
        chk("first_tap_new", 32'(tap_dout), 32'h1234);
        @(negedge clk);
        cfg_wr_addr  = AW'(3);
        cfg_wr_data  = 16'h7FFF;
        cfg_wr_valid = 1'b1;
        chk("busy_wr_ready", 32'(cfg_wr_ready), 32'd0);
        @(posedge clk);
        #1;
        cfg_wr_valid   = 1'b0;
        tap_dout_ready = 1'b1;
        stream(1'b0, c);
        chk("blk_count", 32'(popped), 32'(N));
        pulse_done();

        // async reset at cnt=7, then full restart from tap 0
        start_load(1'b0, '0, '0);
        wait_valid(n);
        e = 0;
        while (popped < 7 && e < 50) begin
            @(posedge clk);
            #1 e++;
        end
        chk("mid_count", 32'(popped), 32'd7);
        reset_n = 1'b0;
        #1;
        chk("mr_valid", 32'(tap_dout_valid), 32'd0);
        chk("mr_dout", 32'(tap_dout), 32'd0);
        chk("mr_fir_en", 32'(fir_enable), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_wr_ready", 32'(cfg_wr_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        start_load(1'b0, '0, '0);
        wait_valid(n);
        chk("rs_first_tap", 32'(tap_dout), 32'h1234);
        stream(1'b0, c);
        chk("rs_count", 32'(popped), 32'(N));
        pulse_done();

`ifdef FIR_TAP_LOADER_CHECKSUM_EN
        for (int k = 0; k < N; k++) write_tap(AW'(k), 16'h8000);
        start_load(1'b0, '0, '0);
        chk("cs_cleared", 32'(tap_checksum), 32'd0);
        wait_valid(n);
        stream(1'b0, c);
        chk("checksum", 32'(tap_checksum), 32'hFFF8_0000);
        pulse_done();
        chk("checksum_hold", 32'(tap_checksum), 32'hFFF8_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
